// File: rtl/ecdsa_vec_pkg.sv
// Shared types and record-slicing helpers for the ECDSA vector player.
// A ROM record is {qx, qy, hash, r, s, exp[1:0]} with fields of width w.
package ecdsa_vec_pkg;

    localparam int unsigned W_MAX   = 521;
    localparam int unsigned REC_MAX = 5 * W_MAX + 2;

    typedef enum logic [1:0] {EXP_VALID, EXP_INVALID, EXP_ACCEPTABLE, EXP_RSVD} exp_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_LOAD, ST_ISSUE, ST_WAIT, ST_CHECK, ST_DONE
    } player_st_e;

    typedef logic [REC_MAX-1:0] rec_t;
    typedef logic [W_MAX-1:0]   fld_t;

    // Field k counted from the LSB side, above the 2-bit expected code.
    function automatic fld_t vec_field(input rec_t rec, input int unsigned w, input int unsigned k);
        rec_t sh;
        fld_t mask;
        sh   = rec >> (2 + k * w);
        mask = {W_MAX{1'b1}} >> (W_MAX - w);
        return W_MAX'(sh) & mask;
    endfunction

    function automatic fld_t vec_s(input rec_t rec, input int unsigned w);
        return vec_field(rec, w, 0);
    endfunction

    function automatic fld_t vec_r(input rec_t rec, input int unsigned w);
        return vec_field(rec, w, 1);
    endfunction

    function automatic fld_t vec_hash(input rec_t rec, input int unsigned w);
        return vec_field(rec, w, 2);
    endfunction

    function automatic fld_t vec_qy(input rec_t rec, input int unsigned w);
        return vec_field(rec, w, 3);
    endfunction

    function automatic fld_t vec_qx(input rec_t rec, input int unsigned w);
        return vec_field(rec, w, 4);
    endfunction

    function automatic exp_e vec_exp(input rec_t rec);
        return exp_e'(rec[1:0]);
    endfunction

endpackage

// File: rtl/ecdsa_vec_scoreboard.sv
// Scores one verdict per check_en against the expected code; saturating result counters
// and first-fail capture.
module ecdsa_vec_scoreboard
    import ecdsa_vec_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             check_en,
    input  exp_e             exp,
    input  logic             ok,
    input  logic             timeout,
    input  logic [AW-1:0]    idx,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] tmo_cnt,
    output logic             fail_vld,
    output logic [AW-1:0]    fail_idx,
    output logic             fail_c
);

    logic pass_c;
    logic acc_c;

    // A timeout overrides the expected code and is always a fail.
    assign pass_c = !timeout && ((exp == EXP_VALID && ok) || (exp == EXP_INVALID && !ok));
    assign acc_c  = !timeout && (exp == EXP_ACCEPTABLE);
    assign fail_c = !pass_c && !acc_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            acc_cnt  <= '0;
            tmo_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_idx <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            acc_cnt  <= '0;
            tmo_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_idx <= '0;
        end else if (check_en) begin
            if (pass_c)  pass_cnt <= sat_inc(pass_cnt);
            if (acc_c)   acc_cnt  <= sat_inc(acc_cnt);
            if (timeout) tmo_cnt  <= sat_inc(tmo_cnt);
            if (fail_c) begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!fail_vld) begin
                    fail_vld <= 1'b1;
                    fail_idx <= idx;
                end
            end
        end
    end

endmodule

// File: rtl/ecdsa_vector_player.sv
// Replays ECDSA verify vectors from a ROM into a verify core and scores each verdict.
module ecdsa_vector_player
    import ecdsa_vec_pkg::*;
#(
    parameter int unsigned W       = 256,
    parameter int unsigned N_VEC   = 512,
    parameter int unsigned AW      = $clog2(N_VEC),
    parameter int unsigned TIMEOUT = 1 << 20,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_fail,
    input  logic [AW:0]      num_vec,
    output logic             busy,
    output logic             done,
    output logic             vec_rd,
    output logic [AW-1:0]    vec_addr,
    input  logic [5*W+1:0]   vec_rdata,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [W-1:0]     req_qx,
    output logic [W-1:0]     req_qy,
    output logic [W-1:0]     req_hash,
    output logic [W-1:0]     req_r,
    output logic [W-1:0]     req_s,
    input  logic             resp_valid,
    input  logic             resp_ok,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] tmo_cnt,
    output logic             fail_vld,
    output logic [AW-1:0]    fail_idx
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    player_st_e    st;
    logic [AW:0]   idx;
    logic [AW:0]   num_q;
    logic [AW:0]   idx_inc;
    logic          sof_q;
    exp_e          exp_q;
    logic          ok_q;
    logic          tmo_q;
    logic [TW-1:0] timer;
    logic          sb_clear;
    logic          fail_c;
    rec_t          rec_ext;

    assign rec_ext  = REC_MAX'(vec_rdata);
    assign idx_inc  = idx + (AW+1)'(1);
    assign sb_clear = (st == ST_IDLE) && start && !abort;

    ecdsa_vec_scoreboard #(.CNT_W(CNT_W), .AW(AW)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (sb_clear),
        .check_en (st == ST_CHECK),
        .exp      (exp_q),
        .ok       (ok_q),
        .timeout  (tmo_q),
        .idx      (idx[AW-1:0]),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .acc_cnt  (acc_cnt),
        .tmo_cnt  (tmo_cnt),
        .fail_vld (fail_vld),
        .fail_idx (fail_idx),
        .fail_c   (fail_c)
    );

    // Sequencer; vec_rd/req_valid are set on entry to FETCH/ISSUE so they coincide with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            idx       <= '0;
            num_q     <= '0;
            sof_q     <= 1'b0;
            exp_q     <= EXP_VALID;
            ok_q      <= 1'b0;
            tmo_q     <= 1'b0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_rd    <= 1'b0;
            vec_addr  <= '0;
            req_valid <= 1'b0;
            req_qx    <= '0;
            req_qy    <= '0;
            req_hash  <= '0;
            req_r     <= '0;
            req_s     <= '0;
        end else begin
            done   <= 1'b0;
            vec_rd <= 1'b0;
            if (abort && st != ST_IDLE && st != ST_DONE) begin
                st        <= ST_DONE;
                busy      <= 1'b0;
                req_valid <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            num_q <= num_vec;
                            sof_q <= stop_on_fail;
                            idx   <= '0;
                            if (num_vec == '0) begin
                                st <= ST_DONE;
                            end else begin
                                st       <= ST_FETCH;
                                busy     <= 1'b1;
                                vec_rd   <= 1'b1;
                                vec_addr <= '0;
                            end
                        end
                    end
                    ST_FETCH: st <= ST_LOAD;
                    ST_LOAD: begin
                        req_qx    <= W'(vec_qx(rec_ext, W));
                        req_qy    <= W'(vec_qy(rec_ext, W));
                        req_hash  <= W'(vec_hash(rec_ext, W));
                        req_r     <= W'(vec_r(rec_ext, W));
                        req_s     <= W'(vec_s(rec_ext, W));
                        exp_q     <= vec_exp(rec_ext);
                        req_valid <= 1'b1;
                        st        <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (req_ready) begin
                            req_valid <= 1'b0;
                            timer     <= '0;
                            st        <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (resp_valid) begin
                            ok_q  <= resp_ok;
                            tmo_q <= 1'b0;
                            st    <= ST_CHECK;
                        end else if (timer == TW'(TIMEOUT - 1)) begin
                            ok_q  <= 1'b0;
                            tmo_q <= 1'b1;
                            st    <= ST_CHECK;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_CHECK: begin
                        idx <= idx_inc;
                        if (idx_inc == num_q || (fail_c && sof_q)) begin
                            st   <= ST_DONE;
                            busy <= 1'b0;
                        end else begin
                            st       <= ST_FETCH;
                            vec_rd   <= 1'b1;
                            vec_addr <= idx_inc[AW-1:0];
                        end
                    end
                    ST_DONE: begin
                        done <= 1'b1;
                        st   <= ST_IDLE;
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecdsa_vector_player.sv
// Directed bench for ecdsa_vector_player with a ROM model and a simple verify-core model.
module tb_ecdsa_vector_player;

    localparam int unsigned W       = 256;
    localparam int unsigned N_VEC   = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort, stop_on_fail;
    logic [AW:0]      num_vec;
    logic             busy, done, vec_rd;
    logic [AW-1:0]    vec_addr;
    logic [5*W+1:0]   vec_rdata = '0;
    logic             req_valid, req_ready;
    logic [W-1:0]     req_qx, req_qy, req_hash, req_r, req_s;
    logic             resp_valid, resp_ok;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, acc_cnt, tmo_cnt;
    logic             fail_vld;
    logic [AW-1:0]    fail_idx;

    logic [5*W+1:0]   rom [N_VEC];
    logic             core_ok [N_VEC];
    int               core_lat [N_VEC];
    logic [AW-1:0]    last_addr = '0;
    logic             rdy_en, inj_rv;
    logic             pend = 1'b0, cur_ok = 1'b0, core_rv = 1'b0, core_ok_q = 1'b0;
    int               cd = 0;
    int               cyc = 0, hs_cyc = 0, hs_total = 0, done_cnt = 0;
    int               n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    assign req_ready  = rdy_en;
    assign resp_valid = core_rv | inj_rv;
    assign resp_ok    = core_ok_q;

    ecdsa_vector_player #(.W(W), .N_VEC(N_VEC), .AW(AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_fail(stop_on_fail),
        .num_vec(num_vec), .busy(busy), .done(done), .vec_rd(vec_rd), .vec_addr(vec_addr),
        .vec_rdata(vec_rdata), .req_valid(req_valid), .req_ready(req_ready),
        .req_qx(req_qx), .req_qy(req_qy), .req_hash(req_hash), .req_r(req_r), .req_s(req_s),
        .resp_valid(resp_valid), .resp_ok(resp_ok),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .acc_cnt(acc_cnt), .tmo_cnt(tmo_cnt),
        .fail_vld(fail_vld), .fail_idx(fail_idx)
    );

    // ROM: data one cycle after the read strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (vec_rd) begin
            vec_rdata <= rom[vec_addr];
            last_addr <= vec_addr;
        end
    end

    // Core: verdict strobe lat cycles after the handshake; lat 0 means never respond
    always @(posedge clk) begin
        core_rv <= 1'b0;
        if (req_valid && req_ready) begin
            hs_total <= hs_total + 1;
            hs_cyc   <= cyc + 1;
            if (core_lat[last_addr] != 0) begin
                pend   <= 1'b1;
                cd     <= core_lat[last_addr];
                cur_ok <= core_ok[last_addr];
            end
        end else if (pend) begin
            if (cd == 1) begin
                core_rv   <= 1'b1;
                core_ok_q <= cur_ok;
                pend      <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] fld(input logic [7:0] tag, input int i);
        logic [31:0] word;
        word = {tag, 24'(i)};
        return {8{word}};
    endfunction

    task automatic set_vec(input int i, input logic [1:0] e, input logic ok, input int lat);
        rom[i] = {fld(8'hA1, i), fld(8'hB2, i), fld(8'hC3, i), fld(8'hD4, i), fld(8'hE5, i), e};
        core_ok[i]  = ok;
        core_lat[i] = lat;
    endtask

    task automatic run(input int n, input logic sof);
        start        = 1'b1;
        num_vec      = (AW+1)'(n);
        stop_on_fail = sof;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_rv(input logic lvl, input string tag);
        int n = 0;
        while (req_valid !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, req_valid, lvl);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, n;
        logic stable;
        for (int i = 0; i < N_VEC; i++) set_vec(i, 2'd0, 1'b1, 1);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_on_fail = 1'b0;
        num_vec = '0; rdy_en = 1'b1; inj_rv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_vec_rd", vec_rd, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail_vld", fail_vld, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: VALID/INVALID/ACCEPTABLE with ok 1/0/0
        set_vec(0, 2'd0, 1'b1, 2); set_vec(1, 2'd1, 1'b0, 3); set_vec(2, 2'd2, 1'b0, 1);
        d0 = done_cnt; h0 = hs_total;
        run(3, 1'b0);
        wait_done("t1_done");
        check("t1_pass", pass_cnt, 2);
        check("t1_acc", acc_cnt, 1);
        check("t1_fail", fail_cnt, 0);
        check("t1_tmo", tmo_cnt, 0);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_handshakes", hs_total - h0, 3);

        // 2: stop on first fail at vector 1
        set_vec(0, 2'd0, 1'b1, 1); set_vec(1, 2'd0, 1'b0, 1);
        set_vec(2, 2'd0, 1'b1, 1); set_vec(3, 2'd0, 1'b1, 1);
        h0 = hs_total;
        run(4, 1'b1);
        wait_done("t2_done");
        check("t2_fail_idx", fail_idx, 1);
        check("t2_fail_vld", fail_vld, 1'b1);
        check("t2_fail", fail_cnt, 1);
        check("t2_pass", pass_cnt, 1);
        check("t2_handshakes", hs_total - h0, 2);

        // 3: vector 0 times out; vector 1 re-issued 3 cycles after expiry
        set_vec(0, 2'd0, 1'b1, 0); set_vec(1, 2'd0, 1'b1, 1);
        run(2, 1'b0);
        n = 0;
        while (tmo_cnt != 1 && n < 200) begin @(negedge clk); n++; end
        check("t3_tmo_seen", tmo_cnt, 1);
        wait_rv(1'b1, "t3_reissue");
        check("t3_reissue_gap", cyc - hs_cyc, TIMEOUT + 3);
        wait_done("t3_done");
        check("t3_tmo", tmo_cnt, 1);
        check("t3_fail", fail_cnt, 1);
        check("t3_pass", pass_cnt, 1);
        check("t3_fail_idx", fail_idx, 0);

        // 4: ready held low 10 cycles; payload stable, one handshake
        set_vec(0, 2'd0, 1'b1, 1);
        rdy_en = 1'b0; h0 = hs_total;
        run(1, 1'b0);
        wait_rv(1'b1, "t4_issue");
        check("t4_qx", req_qx, fld(8'hA1, 0));
        check("t4_qy", req_qy, fld(8'hB2, 0));
        check("t4_hash", req_hash, fld(8'hC3, 0));
        check("t4_r", req_r, fld(8'hD4, 0));
        check("t4_s", req_s, fld(8'hE5, 0));
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (req_valid !== 1'b1 || req_qx !== fld(8'hA1, 0) || req_s !== fld(8'hE5, 0)) stable = 1'b0;
            @(negedge clk);
        end
        check("t4_stable", stable, 1'b1);
        rdy_en = 1'b1;
        wait_done("t4_done");
        check("t4_handshakes", hs_total - h0, 1);
        check("t4_pass", pass_cnt, 1);

        // 5: abort in WAIT, late response ignored
        set_vec(0, 2'd0, 1'b1, 0);
        d0 = done_cnt;
        run(2, 1'b0);
        wait_rv(1'b1, "t5_issue");
        wait_rv(1'b0, "t5_accepted");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("t5_done");
        inj_rv = 1'b1;
        @(negedge clk);
        inj_rv = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_done_pulses", done_cnt - d0, 1);
        check("t5_pass", pass_cnt, 0);
        check("t5_fail", fail_cnt, 0);
        check("t5_tmo", tmo_cnt, 0);
        check("t5_busy", busy, 1'b0);

        // response in the same cycle the timer expires: response wins
        set_vec(0, 2'd0, 1'b1, TIMEOUT - 1);
        run(1, 1'b0);
        wait_done("t7_done");
        check("t7_pass", pass_cnt, 1);
        check("t7_tmo", tmo_cnt, 0);

        // counter saturation and start-while-busy ignored
        for (int i = 0; i < 9; i++) set_vec(i, 2'd2, 1'b0, 1);
        h0 = hs_total;
        run(9, 1'b0);
        repeat (5) @(negedge clk);
        run(1, 1'b0);
        wait_done("t8_done");
        check("t8_acc_sat", acc_cnt, 7);
        check("t8_handshakes", hs_total - h0, 9);

        // 6: reset mid-ISSUE, then an empty run
        set_vec(0, 2'd0, 1'b1, 1);
        rdy_en = 1'b0;
        run(2, 1'b0);
        wait_rv(1'b1, "t6_issue");
        rst_n = 1'b0;
        #1;
        check("t6_rst_req_valid", req_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_qx", req_qx, 0);
        check("t6_rst_acc", acc_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_en = 1'b1;
        @(negedge clk);
        run(0, 1'b0);
        check("t6_done_early", done, 1'b0);
        @(negedge clk);
        check("t6_done", done, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_pass", pass_cnt, 0);
        check("t6_fail", fail_cnt, 0);
        @(negedge clk);
        check("t6_done_clear", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
